// File: rtl/jellyvl_stream_serializer.sv
// Wide-to-narrow stream serializer: takes one S_NUM-lane word per handshake and
// emits its valid lanes one UNIT_WIDTH unit per cycle with packet first/last flags.
module jellyvl_stream_serializer #(
    parameter int UNIT_WIDTH = 8,
    parameter int S_NUM      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = $clog2(S_NUM + 1)
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic                          cke,

    input  logic [S_NUM*UNIT_WIDTH-1:0]   s_data,
    input  logic [CNT_WIDTH-1:0]          s_count,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,

    output logic [UNIT_WIDTH-1:0]         m_data,
    output logic                          m_first,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int IDX_W = (S_NUM > 1) ? $clog2(S_NUM) : 1;
    localparam int LEN_W = $clog2(S_NUM + 1);

    // A zero or oversized count means a full word.
    function automatic logic [LEN_W-1:0] clamp_count(input logic [CNT_WIDTH-1:0] count);
        if (count == '0 || 32'(count) > 32'(S_NUM)) begin
            return LEN_W'(S_NUM);
        end
        return LEN_W'(count);
    endfunction

    function automatic logic [UNIT_WIDTH-1:0] select_lane(
        input logic [S_NUM*UNIT_WIDTH-1:0] word,
        input logic [IDX_W-1:0]            idx
    );
        int lane;
        lane = LSB_FIRST ? int'(idx) : (S_NUM - 1 - int'(idx));
        return word[lane*UNIT_WIDTH +: UNIT_WIDTH];
    endfunction

    function automatic logic is_final_lane(
        input logic [IDX_W-1:0] idx,
        input logic [LEN_W-1:0] cnt
    );
        return LEN_W'(idx) == (cnt - LEN_W'(1));
    endfunction

    logic [S_NUM*UNIT_WIDTH-1:0]   r_buf;
    logic [LEN_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_busy;
    logic                          r_last_w;
    logic                          r_pkt_start;

    logic [UNIT_WIDTH-1:0]         r_m_data;
    logic                          r_m_first;
    logic                          r_m_last;
    logic                          r_m_valid;

    logic                          w_last_lane;
    logic                          w_s_ready;
    logic                          w_in_xfer;
    logic                          w_out_xfer;

    logic [S_NUM*UNIT_WIDTH-1:0]   w_buf_n;
    logic [LEN_W-1:0]              w_cnt_n;
    logic [IDX_W-1:0]              w_idx_n;
    logic                          w_busy_n;
    logic                          w_last_w_n;
    logic                          w_pkt_start_n;

    assign w_last_lane = r_busy & is_final_lane(r_idx, r_cnt);
    // Accepting while the final unit drains lets words chain without a bubble.
    assign w_s_ready   = !reset & cke & (!r_busy | (m_ready & w_last_lane));
    assign w_in_xfer   = s_valid & w_s_ready;
    assign w_out_xfer  = r_busy & m_ready & cke;

    always_comb begin
        w_buf_n       = r_buf;
        w_cnt_n       = r_cnt;
        w_idx_n       = r_idx;
        w_busy_n      = r_busy;
        w_last_w_n    = r_last_w;
        w_pkt_start_n = r_pkt_start;

        if (w_out_xfer) begin
            if (w_last_lane) begin
                w_busy_n      = 1'b0;
                w_pkt_start_n = r_last_w;
            end else begin
                w_idx_n = r_idx + IDX_W'(1);
            end
        end

        // A simultaneous load overrides the end-of-word release.
        if (w_in_xfer) begin
            w_buf_n    = s_data;
            w_cnt_n    = clamp_count(s_count);
            w_idx_n    = '0;
            w_busy_n   = 1'b1;
            w_last_w_n = s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_last_w    <= 1'b0;
            r_pkt_start <= 1'b1;
        end else if (cke) begin
            r_buf       <= w_buf_n;
            r_cnt       <= w_cnt_n;
            r_idx       <= w_idx_n;
            r_busy      <= w_busy_n;
            r_last_w    <= w_last_w_n;
            r_pkt_start <= w_pkt_start_n;
        end
    end

    // Outputs are registered from the next state so they track the held lane exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_data  <= '0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (cke) begin
            r_m_data  <= select_lane(w_buf_n, w_idx_n);
            r_m_first <= w_busy_n & w_pkt_start_n & (w_idx_n == '0);
            r_m_last  <= w_busy_n & w_last_w_n & is_final_lane(w_idx_n, w_cnt_n);
            r_m_valid <= w_busy_n;
        end
    end

    assign s_ready = w_s_ready;
    assign m_data  = r_m_data;
    assign m_first = r_m_first;
    assign m_last  = r_m_last;
    assign m_valid = r_m_valid;

endmodule

// File: tb/tb_jellyvl_stream_serializer.sv
// Bench for jellyvl_stream_serializer: two instances (LSB-first and MSB-first) share
// stimulus and are compared against a queue of expected units built per accepted word.
module tb_jellyvl_stream_serializer;

    localparam int UW = 8;
    localparam int SN = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cke;
    logic [SN*UW-1:0]  s_data;
    logic [CW-1:0]     s_count;
    logic              s_last;
    logic              s_valid;
    logic              m_ready;

    logic              s_ready_a, s_ready_b;
    logic [UW-1:0]     m_data_a, m_data_b;
    logic              m_first_a, m_first_b;
    logic              m_last_a, m_last_b;
    logic              m_valid_a, m_valid_b;

    always #5 clk = ~clk;

    jellyvl_stream_serializer #(.UNIT_WIDTH(UW), .S_NUM(SN), .LSB_FIRST(1'b1), .CNT_WIDTH(CW)) u_dut_lsb (
        .reset(reset), .clk(clk), .cke(cke),
        .s_data(s_data), .s_count(s_count), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_first(m_first_a), .m_last(m_last_a), .m_valid(m_valid_a), .m_ready(m_ready)
    );

    jellyvl_stream_serializer #(.UNIT_WIDTH(UW), .S_NUM(SN), .LSB_FIRST(1'b0), .CNT_WIDTH(CW)) u_dut_msb (
        .reset(reset), .clk(clk), .cke(cke),
        .s_data(s_data), .s_count(s_count), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_first(m_first_b), .m_last(m_last_b), .m_valid(m_valid_b), .m_ready(m_ready)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  k;
        logic        first;
        logic        last;
    } unit_t;

    unit_t q[$];
    bit    pkt_open_next;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check, then advance the model.
    task automatic step(input bit rst, input bit ck, input bit sv, input logic [31:0] d,
                        input logic [2:0] c, input bit sl, input bit mr);
        bit          exp_rdy, xin, xout;
        logic [31:0] w;
        int          k, n;
        unit_t       u;
        @(negedge clk);
        reset = rst; cke = ck; s_valid = sv; s_data = d; s_count = c; s_last = sl; m_ready = mr;
        #1;
        exp_rdy = !rst && ck && (q.size() == 0 || (mr && q.size() == 1));
        check("s_ready_lsb", 32'(s_ready_a), 32'(exp_rdy));
        check("s_ready_msb", 32'(s_ready_b), 32'(exp_rdy));
        check("m_valid_lsb", 32'(m_valid_a), 32'(q.size() != 0));
        check("m_valid_msb", 32'(m_valid_b), 32'(q.size() != 0));
        if (q.size() != 0) begin
            w = q[0].word;
            k = int'(q[0].k);
            check("m_data_lsb",  32'(m_data_a),  32'(w[k*8 +: 8]));
            check("m_data_msb",  32'(m_data_b),  32'(w[(SN-1-k)*8 +: 8]));
            check("m_first_lsb", 32'(m_first_a), 32'(q[0].first));
            check("m_first_msb", 32'(m_first_b), 32'(q[0].first));
            check("m_last_lsb",  32'(m_last_a),  32'(q[0].last));
            check("m_last_msb",  32'(m_last_b),  32'(q[0].last));
        end
        xin  = sv && exp_rdy;
        xout = (q.size() != 0) && mr && ck && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            pkt_open_next = 1'b1;
        end else begin
            if (xout) void'(q.pop_front());
            if (xin) begin
                n = (c == 0 || int'(c) > SN) ? SN : int'(c);
                for (int i = 0; i < n; i++) begin
                    u.word  = d;
                    u.k     = 3'(i);
                    u.first = (i == 0) && pkt_open_next;
                    u.last  = (i == n - 1) && sl;
                    q.push_back(u);
                end
                pkt_open_next = sl;
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 1, 0, 32'h0, 3'd0, 0, 1);
    endtask

    initial begin
        bit rs, ck, sv, sl, mr;
        bit [2:0] rb;
        reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_data = '0; s_count = '0; s_last = 1'b0; m_ready = 1'b0;
        pkt_open_next = 1'b1;

        step(1, 1, 0, 32'h0, 3'd0, 0, 0);
        step(1, 1, 0, 32'h0, 3'd0, 0, 1);
        @(negedge clk);
        check("reset_m_data_lsb",  32'(m_data_a),  32'h0);
        check("reset_m_data_msb",  32'(m_data_b),  32'h0);
        check("reset_m_first_lsb", 32'(m_first_a), 32'h0);
        check("reset_m_last_lsb",  32'(m_last_a),  32'h0);

        // basic word
        step(0, 1, 1, 32'h44332211, 3'd4, 1, 1);
        idle(4);

        // back-to-back words chained on the final unit
        step(0, 1, 1, 32'h44332211, 3'd4, 0, 1);
        idle(3);
        step(0, 1, 1, 32'h88776655, 3'd4, 1, 1);
        idle(4);

        // partial and clamped counts
        step(0, 1, 1, 32'hAABBCCDD, 3'd2, 1, 1);
        idle(2);
        step(0, 1, 1, 32'hAABBCCDD, 3'd0, 1, 1);
        idle(4);
        step(0, 1, 1, 32'h10203040, 3'd6, 1, 1);
        idle(4);

        // backpressure with a pending second word
        step(0, 1, 1, 32'hDEADBEEF, 3'd4, 1, 1);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 1);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 0);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 0);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 1);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 1);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 0);
        step(0, 1, 1, 32'hCAFEF00D, 3'd3, 1, 1);
        idle(4);

        // clock enable dropped mid-word
        step(0, 1, 1, 32'h0A0B0C0D, 3'd4, 1, 1);
        idle(1);
        step(0, 0, 1, 32'h11111111, 3'd4, 0, 1);
        step(0, 0, 0, 32'h0, 3'd0, 0, 1);
        step(0, 0, 1, 32'h22222222, 3'd1, 1, 0);
        idle(4);

        // reset at lane 2 of an open packet
        step(0, 1, 1, 32'h55667788, 3'd4, 0, 1);
        idle(2);
        step(1, 1, 0, 32'h0, 3'd0, 0, 1);
        idle(1);
        step(0, 1, 1, 32'h99AABBCC, 3'd1, 1, 1);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 63) == 0);
            ck = ($urandom_range(0, 7) != 0);
            sv = 1'($urandom_range(0, 1));
            sl = 1'($urandom_range(0, 1));
            mr = ($urandom_range(0, 3) != 0);
            rb = 3'($urandom_range(0, 7));
            step(rs, ck, sv, $urandom, rb, sl, mr);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
